// File: rtl/tortoise_pkg.sv
// Shared types for the tortoise core: scoreboard entries,
// writeback bundles and ring sizing constants.
package tortoise_pkg;

   localparam int CONFIG_SB_ENTRIES = 8;
   localparam int NR_WB_PORTS       = 2;
   localparam int SB_IDX_W          = $clog2(CONFIG_SB_ENTRIES);

   typedef logic [SB_IDX_W-1:0] sb_idx_t;
   typedef logic [31:0]         data_t;

   typedef enum logic [1:0] {
      FU_ALU,
      FU_LSU,
      FU_MUL,
      FU_CSR
   } fu_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] cause;
   } exception_t;

   typedef struct packed {
      logic  valid;
      data_t value;
   } result_t;

   typedef struct packed {
      logic       valid;
      sb_idx_t    trans_id;
      fu_t        fu;
      logic [4:0] rd;
      data_t      pc;
      result_t    result;
      exception_t ex;
   } scoreboard_entry_t;

   typedef struct packed {
      logic       valid;
      sb_idx_t    trans_id;
      data_t      data;
      exception_t ex;
   } sb_wb_t;

endpackage

// File: rtl/scoreboard_ctrl.sv
// Scoreboard ring: in-order issue, out-of-order writeback,
// in-order commit, with a full flush.
module scoreboard_ctrl
   import tortoise_pkg::*;
#(
   parameter int SB_ENTRIES  = CONFIG_SB_ENTRIES,
   parameter int NR_WB_PORTS = tortoise_pkg::NR_WB_PORTS
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic                          issue_valid_i,
   input  scoreboard_entry_t             issue_entry_i,
   output logic                          issue_ready_o,
   output logic [$clog2(SB_ENTRIES)-1:0] issue_id_o,
   input  sb_wb_t                        wb_i [NR_WB_PORTS],
   output logic                          commit_valid_o,
   output scoreboard_entry_t             commit_entry_o,
   input  logic                          commit_ack_i,
   output logic [$clog2(SB_ENTRIES):0]   count_o
);

   localparam int IDX_W = $clog2(SB_ENTRIES);
   localparam int CNT_W = IDX_W + 1;

   scoreboard_entry_t mem_q [SB_ENTRIES];
   scoreboard_entry_t mem_d [SB_ENTRIES];
   logic [SB_ENTRIES-1:0] occ_q, occ_d;
   logic [SB_ENTRIES-1:0] done_q, done_d;
   logic [IDX_W-1:0]      head_q, head_d;
   logic [IDX_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   sb_wb_t wb_sel [SB_ENTRIES];
   logic   issue_fire;
   logic   commit_fire;

   // Scanning from the top down lets the lowest port index win.
   function automatic sb_wb_t wb_pick(
      input sb_wb_t           wb [NR_WB_PORTS],
      input logic [IDX_W-1:0] idx
   );
      sb_wb_t r;
      r = '0;
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
         if (wb[p].valid && wb[p].trans_id == idx) begin
            r = wb[p];
         end
      end
      return r;
   endfunction

   always_comb begin
      for (int s = 0; s < SB_ENTRIES; s++) begin
         wb_sel[s] = wb_pick(wb_i, IDX_W'(s));
      end
   end

   assign issue_ready_o  = (cnt_q < CNT_W'(SB_ENTRIES)) & ~flush_i;
   assign issue_id_o     = tail_q;
   assign commit_valid_o = occ_q[head_q] & done_q[head_q];
   assign commit_entry_o = mem_q[head_q];
   assign count_o        = cnt_q;

   assign issue_fire  = issue_valid_i & issue_ready_o;
   assign commit_fire = commit_ack_i & commit_valid_o;

   always_comb begin
      mem_d  = mem_q;
      occ_d  = occ_q;
      done_d = done_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;

      if (flush_i) begin
         occ_d  = '0;
         done_d = '0;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         for (int s = 0; s < SB_ENTRIES; s++) begin
            if (wb_sel[s].valid && occ_q[s] && !done_q[s]) begin
               mem_d[s].result.value = wb_sel[s].data;
               mem_d[s].result.valid = 1'b1;
               mem_d[s].ex           = wb_sel[s].ex;
               done_d[s]             = 1'b1;
            end
         end

         if (commit_fire) begin
            occ_d[head_q]  = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
         end

         // A faulted entry never reaches an FU, so it is done at issue.
         if (issue_fire) begin
            mem_d[tail_q]          = issue_entry_i;
            mem_d[tail_q].trans_id = tail_q;
            mem_d[tail_q].valid    = 1'b1;
            occ_d[tail_q]          = 1'b1;
            done_d[tail_q]         = issue_entry_i.ex.valid;
            tail_d                 = tail_q + 1'b1;
         end

         cnt_d = cnt_q + CNT_W'(issue_fire) - CNT_W'(commit_fire);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         occ_q  <= '0;
         done_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         occ_q  <= occ_d;
         done_q <= done_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Randomized bench for scoreboard_ctrl against an in-order
// queue model of the scoreboard.
module tb_scoreboard_ctrl;
   import tortoise_pkg::*;

   localparam int N = CONFIG_SB_ENTRIES;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              iv;
   logic              ack;
   scoreboard_entry_t ient;
   sb_wb_t            wb [NR_WB_PORTS];
   logic              ready;
   logic              cv;
   logic [2:0]        iid;
   scoreboard_entry_t cent;
   logic [3:0]        cnt;

   always #5 clk = ~clk;

   scoreboard_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .issue_valid_i  (iv),
      .issue_entry_i  (ient),
      .issue_ready_o  (ready),
      .issue_id_o     (iid),
      .wb_i           (wb),
      .commit_valid_o (cv),
      .commit_entry_o (cent),
      .commit_ack_i   (ack),
      .count_o        (cnt)
   );

   int errs   = 0;
   int checks = 0;

   task automatic check(input string tag,
                        input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: the in-flight entries are just an ordered list of ids.
   int                q [$];
   scoreboard_entry_t m_ent [N];
   bit                m_done [N];
   int                m_tail;

   function automatic bit inflight(input int id);
      foreach (q[i]) if (q[i] == id) return 1'b1;
      return 1'b0;
   endfunction

   function automatic scoreboard_entry_t mk_ent(input bit exv);
      scoreboard_entry_t e;
      e              = '0;
      e.fu           = fu_t'($urandom_range(0, 3));
      e.rd           = 5'($urandom);
      e.pc           = $urandom;
      e.ex.valid     = exv;
      e.ex.cause     = exv ? 5'($urandom) : 5'd0;
      e.trans_id     = sb_idx_t'($urandom);
      return e;
   endfunction

   function automatic sb_wb_t mk_wb(input int id, input data_t d,
                                    input bit exv);
      sb_wb_t w;
      w          = '0;
      w.valid    = 1'b1;
      w.trans_id = sb_idx_t'(id);
      w.data     = d;
      w.ex.valid = exv;
      w.ex.cause = exv ? 5'($urandom) : 5'd0;
      return w;
   endfunction

   task automatic step(input bit v, input scoreboard_entry_t e,
                       input sb_wb_t w0, input sb_wb_t w1,
                       input bit a, input bit f);
      bit     rdy;
      bit     cvx;
      sb_wb_t w;
      scoreboard_entry_t ne;
      iv    = v;
      ient  = e;
      wb[0] = w0;
      wb[1] = w1;
      ack   = a;
      flush = f;
      #1;
      rdy = (q.size() < N) && !f;
      cvx = (q.size() > 0) && m_done[q[0]];
      check("issue_ready", 128'(ready), 128'(rdy));
      check("issue_id", 128'(iid), 128'(m_tail));
      check("count", 128'(cnt), 128'(q.size()));
      check("commit_valid", 128'(cv), 128'(cvx));
      if (cvx) check("commit_entry", 128'(cent), 128'(m_ent[q[0]]));
      @(posedge clk);
      if (f) begin
         q.delete();
         m_tail = 0;
      end else begin
         for (int p = 0; p < NR_WB_PORTS; p++) begin
            w = (p == 0) ? w0 : w1;
            if (w.valid && inflight(int'(w.trans_id)) &&
                !m_done[w.trans_id]) begin
               m_ent[w.trans_id].result.value = w.data;
               m_ent[w.trans_id].result.valid = 1'b1;
               m_ent[w.trans_id].ex           = w.ex;
               m_done[w.trans_id]             = 1'b1;
            end
         end
         if (a && cvx) void'(q.pop_front());
         if (v && rdy) begin
            ne          = e;
            ne.trans_id = sb_idx_t'(m_tail);
            ne.valid    = 1'b1;
            m_ent[m_tail]  = ne;
            m_done[m_tail] = e.ex.valid;
            q.push_back(m_tail);
            m_tail = (m_tail + 1) % N;
         end
      end
      @(negedge clk);
   endtask

   sb_wb_t            nw;
   scoreboard_entry_t ne0;

   initial begin
      nw    = '0;
      ne0   = '0;
      rst   = 1'b1;
      flush = 1'b0;
      iv    = 1'b0;
      ack   = 1'b0;
      ient  = '0;
      wb[0] = '0;
      wb[1] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_tail = 0;

      step(0, ne0, nw, nw, 0, 0);
      for (int i = 0; i < 3; i++) step(1, mk_ent(0), nw, nw, 0, 0);
      step(0, ne0, mk_wb(2, $urandom, 0), nw, 0, 0);
      step(0, ne0, mk_wb(0, $urandom, 0), nw, 0, 0);
      step(0, ne0, nw, nw, 0, 0);
      step(0, ne0, nw, nw, 1, 0);
      step(0, ne0, nw, nw, 1, 0);
      step(0, ne0, nw, mk_wb(1, $urandom, 1), 0, 0);
      step(0, ne0, nw, nw, 1, 0);
      step(0, ne0, nw, nw, 1, 0);
      step(0, ne0, nw, nw, 0, 0);

      step(0, ne0, nw, nw, 0, 1);
      step(1, mk_ent(1), nw, nw, 0, 0);
      for (int i = 0; i < 7; i++) step(1, mk_ent(0), nw, nw, 0, 0);
      step(1, mk_ent(0), nw, nw, 1, 0);
      step(1, mk_ent(0), nw, nw, 0, 0);
      check("wrap_id", 128'(m_tail), 128'(1));

      step(0, ne0, mk_wb(3, 32'hAAAA_0003, 0),
           mk_wb(3, 32'hBBBB_0003, 0), 0, 0);
      check("dual_wb_value", 128'(m_ent[3].result.value),
            128'(32'hAAAA_0003));
      step(0, ne0, mk_wb(3, 32'hCCCC_0003, 1), nw, 0, 0);
      foreach (q[i]) begin
         if (q[i] != 3) step(0, ne0, mk_wb(q[i], $urandom, 0), nw, 1, 0);
      end
      for (int i = 0; i < 10; i++) step(0, ne0, nw, nw, 1, 0);

      step(0, ne0, nw, nw, 0, 1);
      step(1, mk_ent(1), nw, nw, 0, 0);
      for (int i = 0; i < 4; i++) step(1, mk_ent(0), nw, nw, 0, 0);
      step(1, mk_ent(0), mk_wb(2, $urandom, 0), nw, 1, 1);
      step(0, ne0, mk_wb(4, $urandom, 0), nw, 1, 0);
      step(0, ne0, nw, nw, 1, 0);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 7,
              mk_ent($urandom_range(0, 9) == 0),
              ($urandom_range(0, 1) == 1) ?
                 mk_wb($urandom_range(0, N - 1), $urandom,
                       $urandom_range(0, 9) == 0) : nw,
              ($urandom_range(0, 1) == 1) ?
                 mk_wb($urandom_range(0, N - 1), $urandom, 0) : nw,
              $urandom_range(0, 9) < 6,
              $urandom_range(0, 99) < 2);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
